novacore_cfg_tx: RTL
====================

NOVACORE_CFG_TX -- requirements
Module: novacore_cfg_tx

Interface
REQ-001 SHALL have parameter BUS_W, default 28, c_bus width.
REQ-002 SHALL have parameter UID_W, default 4, c_uid width.
REQ-003 SHALL have parameter DIM_W, default 4, c_dimension width.
REQ-004 SHALL have parameter HALF, default 4, c_clk half-period in clk cycles (1..255).
REQ-005 SHALL have parameter DEPTH, default 4, word FIFO depth (power of 2, 2..16).
REQ-006 clk  input  1  sole clock; all logic on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 start  input  1  one-cycle pulse opening a configuration session.
REQ-009 in_valid / in_ready  input / output  1 / 1  word-push handshake; transfer when both high.
REQ-010 in_bus, in_uid, in_dim  input  BUS_W, UID_W, DIM_W  word payload.
REQ-011 in_dimswitch, in_last  input  1, 1  dimension-switch flag; final word of session.
REQ-012 mode  output  1  high for the whole session (fabric in configuration mode).
REQ-013 c_clk  output  1  configuration strobe toward the fabric.
REQ-014 c_bus, c_uid, c_dimension, c_dimswitch  output  BUS_W, UID_W, DIM_W, 1  registered word fields.
REQ-015 busy, done  output  1, 1  session active; one-cycle end-of-session pulse.
REQ-016 words_sent  output  16  words transmitted in current or last session.

Function
REQ-017 FIFO: in_ready = not full; a push is accepted in any state, including IDLE.
REQ-018 FSM states: IDLE, LOAD, LOW, HIGH, TAIL.
REQ-019 IDLE: start -> mode=1, busy=1, words_sent=0, go LOAD; start while busy is ignored.
REQ-020 LOAD: FIFO empty -> stay in LOAD (mode held, c_clk low); else pop one word into c_* registers, go LOW.
REQ-021 LOW: c_clk=0 for exactly HALF cycles, then HIGH.
REQ-022 HIGH: c_clk=1 for exactly HALF cycles; on exit c_clk=0, words_sent saturating +1, last flag set -> TAIL, else LOAD.
REQ-023 c_* fields SHALL remain stable from the LOAD pop until the next pop; the fabric samples on the c_clk rising edge.
REQ-024 Word period with a non-empty FIFO SHALL be 2*HALF+1 clk cycles (1 LOAD + HALF LOW + HALF HIGH).
REQ-025 TAIL: hold mode=1 for HALF cycles, then mode=0, busy=0, done=1 for one cycle, go IDLE.
REQ-026 Words pushed after the last-flag word remain queued for the next session.
REQ-027 Simultaneous push and pop when full: the pop frees the slot, but in_ready reflects pre-pop state (no same-cycle bypass).

Reset
REQ-028 rst SHALL asynchronously force IDLE, empty FIFO, and mode=0, c_clk=0, c_bus=0, c_uid=0, c_dimension=0, c_dimswitch=0, busy=0, done=0, words_sent=0, in_ready=0 while rst is high, 1 after release.
REQ-029 rst mid-session SHALL abort immediately without a done pulse; queued words are discarded.

Configuration
REQ-030 NOVACORE_CFG_TX_COUNT_EN defined: words_sent operates per REQ-019/REQ-022.
REQ-031 NOVACORE_CFG_TX_COUNT_EN undefined: counter logic absent, words_sent tied to 0; all other behaviour identical.

Verification
REQ-032 HALF=4: push 1 word (bus=0xABCDEF1, uid=3, last=1), pulse start -> one c_clk high pulse of 4 cycles, c_bus=0xABCDEF1 at rise, done 4 cycles after fall, words_sent=1.
REQ-033 Push 4 words, no start -> in_ready=0 after 4th push, mode=0, c_clk idle; start -> 4 pulses, 9-cycle period.
REQ-034 start with empty FIFO -> mode=1, c_clk static low; push 1 word with last=1 one hundred cycles later -> single pulse, then done.
REQ-035 rst asserted during HIGH of word 2 -> same-cycle c_clk=0, mode=0, no done, FIFO empty after release.
REQ-036 Second start during session -> ignored; pulse count and words_sent unchanged.
REQ-037 Build without NOVACORE_CFG_TX_COUNT_EN, repeat REQ-032 -> identical waveforms, words_sent=0.

Source files
------------

// File: rtl/novacore_cfg_tx.sv
`default_nettype none
// ============================================================================
//  Module      : novacore_cfg_tx
//  Description : Configuration-word transmitter with a word FIFO and a slow
//                c_clk strobe. Define NOVACORE_CFG_TX_COUNT_EN to build the
//                words_sent counter; otherwise words_sent is tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module novacore_cfg_tx #(
    parameter int BUS_W = 28,
    parameter int UID_W = 4,
    parameter int DIM_W = 4,
    parameter int HALF  = 4,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BUS_W-1:0]  in_bus,
    input  logic [UID_W-1:0]  in_uid,
    input  logic [DIM_W-1:0]  in_dim,
    input  logic              in_dimswitch,
    input  logic              in_last,
    output logic              mode,
    output logic              c_clk,
    output logic [BUS_W-1:0]  c_bus,
    output logic [UID_W-1:0]  c_uid,
    output logic [DIM_W-1:0]  c_dimension,
    output logic              c_dimswitch,
    output logic              busy,
    output logic              done,
    output logic [15:0]       words_sent
);

    localparam int         AW       = $clog2(DEPTH);
    localparam int         WW       = BUS_W + UID_W + DIM_W + 2;
    localparam logic [7:0] HALF_END = 8'(HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_LOW  = 3'd2,
        S_HIGH = 3'd3,
        S_TAIL = 3'd4
    } state_t;

    // ------------------------------------------------------------------ FIFO
    logic [WW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ready_q, ready_d;
    logic          w_push, w_pop, w_empty;
    logic [WW-1:0] w_wdata, w_rdata;

    assign w_push   = in_valid & ready_q;
    assign w_empty  = (count_q == '0);
    assign w_wdata  = {in_dimswitch, in_last, in_dim, in_uid, in_bus};
    assign w_rdata  = mem_q[rd_ptr_q];
    assign in_ready = ready_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (w_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        // Ready is registered from the next occupancy, so a pop never
        // opens a slot to a push in the same cycle.
        ready_d = (count_d != (AW+1)'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= w_wdata;
    end

    // ------------------------------------------------------------------- FSM
    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             mode_q, mode_d, c_clk_q, c_clk_d;
    logic [BUS_W-1:0] c_bus_q, c_bus_d;
    logic [UID_W-1:0] c_uid_q, c_uid_d;
    logic [DIM_W-1:0] c_dim_q, c_dim_d;
    logic             c_dsw_q, c_dsw_d, last_q, last_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             w_half_end;

    assign w_half_end = (cnt_q == HALF_END);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        c_clk_d = c_clk_q;
        c_bus_d = c_bus_q;
        c_uid_d = c_uid_q;
        c_dim_d = c_dim_q;
        c_dsw_d = c_dsw_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        w_pop   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    mode_d  = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_LOAD: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    {c_dsw_d, last_d, c_dim_d, c_uid_d, c_bus_d} = w_rdata;
                    cnt_d   = '0;
                    state_d = S_LOW;
                end
            end
            S_LOW: begin
                if (w_half_end) begin
                    cnt_d   = '0;
                    c_clk_d = 1'b1;
                    state_d = S_HIGH;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_HIGH: begin
                if (w_half_end) begin
                    cnt_d   = '0;
                    c_clk_d = 1'b0;
                    state_d = last_q ? S_TAIL : S_LOAD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_TAIL: begin
                if (w_half_end) begin
                    cnt_d   = '0;
                    mode_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mode_q   <= 1'b0;
            c_clk_q  <= 1'b0;
            c_bus_q  <= '0;
            c_uid_q  <= '0;
            c_dim_q  <= '0;
            c_dsw_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            c_clk_q  <= c_clk_d;
            c_bus_q  <= c_bus_d;
            c_uid_q  <= c_uid_d;
            c_dim_q  <= c_dim_d;
            c_dsw_q  <= c_dsw_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign mode        = mode_q;
    assign c_clk       = c_clk_q;
    assign c_bus       = c_bus_q;
    assign c_uid       = c_uid_q;
    assign c_dimension = c_dim_q;
    assign c_dimswitch = c_dsw_q;
    assign busy        = busy_q;
    assign done        = done_q;

    // ------------------------------------------------------------ word count
`ifdef NOVACORE_CFG_TX_COUNT_EN
    logic [15:0] words_q, words_d;

    always_comb begin
        words_d = words_q;
        if (state_q == S_IDLE && start)
            words_d = '0;
        else if (state_q == S_HIGH && w_half_end && words_q != 16'hFFFF)
            words_d = words_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) words_q <= '0;
        else     words_q <= words_d;
    end

    assign words_sent = words_q;
`else
    assign words_sent = '0;
`endif

endmodule
`default_nettype wire
